// File: rtl/data_break_ctrl_pkg.sv
// data_break_ctrl_pkg: shared data-break state type and default parameters
package data_break_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, WAIT, DB0, DB1, GUARD} dbSTATE_t;
    localparam int DB_MAX_WAIT = 64;
endpackage

// File: rtl/data_break_ctrl.sv
// data_break_ctrl: steals one memory cycle per disk data-break request
module data_break_ctrl
    import data_break_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = DB_MAX_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        data_break,
    input  logic        to_disk,
    input  logic [14:0] dma_addr,
    input  logic [11:0] dma_wdata,
    input  logic        cpu_idle,
    output logic        break_in_prog,
    output logic        db_ack,
    output logic [11:0] dma_rdata,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [11:0] mem_rdata,
    output logic        late_err
);
    localparam int CW = $clog2(MAX_WAIT) + 1;
    dbSTATE_t      state, state_n;
    logic [CW-1:0] wait_cnt;
    logic          to_disk_q;
    logic [14:0]   addr_q;
    logic [11:0]   wdata_q;
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = data_break ? (cpu_idle ? DB0 : WAIT) : IDLE;
            WAIT:    state_n = !data_break ? IDLE : (cpu_idle ? DB0 : WAIT);
            DB0:     state_n = DB1;
            DB1:     state_n = GUARD;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            late_err  <= 1'b0;
            to_disk_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dma_rdata <= '0;
        end else if (clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
            late_err <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n == DB0) begin
                to_disk_q <= to_disk;
                addr_q    <= dma_addr;
                wdata_q   <= dma_wdata;
            end
            if (state != WAIT)
                wait_cnt <= '0;
            else if (wait_cnt != CW'(MAX_WAIT))
                wait_cnt <= wait_cnt + 1'b1;
            // Flag on the edge the counter reaches MAX_WAIT
            if (state == WAIT && wait_cnt == CW'(MAX_WAIT - 1))
                late_err <= 1'b1;
            if (state == DB1 && to_disk_q)
                dma_rdata <= mem_rdata;
        end
    end
    assign break_in_prog = (state == DB0) || (state == DB1) || (state == GUARD);
    assign db_ack        = state == DB1;
    assign mem_re        = (state == DB0) && to_disk_q;
    assign mem_we        = (state == DB0) && !to_disk_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
endmodule

// File: tb/tb_data_break_ctrl.sv
// tb_data_break_ctrl: scoreboard bench for data_break_ctrl with a memory model
module tb_data_break_ctrl;
    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [11:0] data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset, clear, data_break, to_disk, cpu_idle;
    logic [14:0] dma_addr;
    logic [11:0] dma_wdata;
    logic        break_in_prog, db_ack, mem_re, mem_we, late_err;
    logic [11:0] dma_rdata, mem_wdata;
    logic [14:0] mem_addr;
    logic [11:0] mem_rdata = '0;
    logic [11:0] mem [0:32767];

    xfer_t sb[$];
    int    strobe_cyc[$];
    int    checks = 0, errors = 0, cyc = 0, ack_cnt = 0, n0 = 0;

    data_break_ctrl #(.MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .data_break(data_break),
        .to_disk(to_disk), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .cpu_idle(cpu_idle), .break_in_prog(break_in_prog), .db_ack(db_ack),
        .dma_rdata(dma_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .late_err(late_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (db_ack) ack_cnt++;
        if (mem_re || mem_we) begin
            strobe_cyc.push_back(cyc);
            if (sb.size() == 0) check("unexpected_strobe", 1, 0);
            else begin
                xfer_t x;
                x = sb.pop_front();
                check("sb_we", {31'd0, mem_we}, {31'd0, x.we});
                check("sb_one_strobe", {31'd0, mem_re & mem_we}, 0);
                check("sb_addr", {17'd0, mem_addr}, {17'd0, x.addr});
                if (x.we) check("sb_wdata", {20'd0, mem_wdata}, {20'd0, x.data});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_bip"}, {31'd0, break_in_prog}, 0);
        check({tag, "_ack"}, {31'd0, db_ack}, 0);
        check({tag, "_strobes"}, {30'd0, mem_re, mem_we}, 0);
        check({tag, "_addr"}, {17'd0, mem_addr}, 0);
        check({tag, "_wdata"}, {20'd0, mem_wdata}, 0);
        check({tag, "_rdata"}, {20'd0, dma_rdata}, 0);
        check({tag, "_late"}, {31'd0, late_err}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, required finish before 200000");
        $fatal(1);
    end

    initial begin
        mem[15'o12345] = 12'o7070;
        mem[15'o00007] = 12'o4321;
        reset = 0; clear = 0; data_break = 0; to_disk = 0; cpu_idle = 0;
        dma_addr = '0; dma_wdata = '0;
        #1;
        all_zero("reset");
        tick; tick;
        reset = 1;
        tick;
        check("reset_idle", {31'd0, break_in_prog}, 0);

        // read with the CPU idle
        data_break = 1; to_disk = 1; dma_addr = 15'o12345; cpu_idle = 1;
        sb.push_back('{1'b0, 15'o12345, 12'o0});
        tick;
        check("rd_re", {31'd0, mem_re}, 1);
        check("rd_bip", {31'd0, break_in_prog}, 1);
        dma_addr = 15'o77777; to_disk = 0;
        tick;
        check("rd_ack", {31'd0, db_ack}, 1);
        check("rd_re_off", {31'd0, mem_re}, 0);
        data_break = 0;
        tick;
        check("rd_rdata", {20'd0, dma_rdata}, {20'd0, 12'o7070});
        check("rd_guard_ack", {31'd0, db_ack}, 0);
        check("rd_guard_bip", {31'd0, break_in_prog}, 1);
        tick;
        check("rd_idle_bip", {31'd0, break_in_prog}, 0);

        // write with the CPU busy for 5 cycles
        data_break = 1; to_disk = 0; cpu_idle = 0;
        dma_addr = 15'o00200; dma_wdata = 12'o1234;
        sb.push_back('{1'b1, 15'o00200, 12'o1234});
        for (int k = 1; k <= 5; k++) begin
            tick;
            check("wr_wait_bip", {31'd0, break_in_prog}, 0);
            check("wr_wait_we", {31'd0, mem_we}, 0);
        end
        cpu_idle = 1;
        tick;
        check("wr_we", {31'd0, mem_we}, 1);
        dma_wdata = 12'o7777;
        tick;
        check("wr_ack", {31'd0, db_ack}, 1);
        data_break = 0;
        tick; tick;
        check("wr_late", {31'd0, late_err}, 0);
        check("wr_mem", {20'd0, mem[15'o00200]}, {20'd0, 12'o1234});
        check("wr_rdata_hold", {20'd0, dma_rdata}, {20'd0, 12'o7070});

        // starvation
        data_break = 1; to_disk = 1; dma_addr = 15'o00007; cpu_idle = 0;
        sb.push_back('{1'b0, 15'o00007, 12'o0});
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k == 8) check("starve_late_before", {31'd0, late_err}, 0);
            if (k == 9) check("starve_late_set", {31'd0, late_err}, 1);
            if (k == 20) check("starve_bip", {31'd0, break_in_prog}, 0);
        end
        cpu_idle = 1;
        tick;
        check("starve_re", {31'd0, mem_re}, 1);
        tick;
        check("starve_ack", {31'd0, db_ack}, 1);
        data_break = 0;
        tick;
        check("starve_rdata", {20'd0, dma_rdata}, {20'd0, 12'o4321});
        tick;
        check("starve_sticky", {31'd0, late_err}, 1);
        clear = 1;
        tick;
        clear = 0;
        check("starve_cleared", {31'd0, late_err}, 0);

        // request held high through GUARD
        n0 = strobe_cyc.size();
        data_break = 1; cpu_idle = 1; to_disk = 0;
        dma_addr = 15'o00300; dma_wdata = 12'o1111;
        sb.push_back('{1'b1, 15'o00300, 12'o1111});
        tick;
        dma_addr = 15'o00301; dma_wdata = 12'o2222;
        sb.push_back('{1'b1, 15'o00301, 12'o2222});
        tick; tick;
        check("held_guard_we", {31'd0, mem_we}, 0);
        tick;
        check("held_idle_bip", {31'd0, break_in_prog}, 0);
        check("held_one_strobe", strobe_cyc.size(), n0 + 1);
        tick;
        check("held_second_we", {31'd0, mem_we}, 1);
        data_break = 0;
        tick; tick; tick;
        check("held_two_strobes", strobe_cyc.size(), n0 + 2);
        if (strobe_cyc.size() == n0 + 2)
            check("held_gap", strobe_cyc[n0 + 1] - strobe_cyc[n0], 4);
        check("held_mem", {20'd0, mem[15'o00301]}, {20'd0, 12'o2222});

        // clear during DB0 of a write
        n0 = ack_cnt;
        data_break = 1; cpu_idle = 1; to_disk = 0;
        dma_addr = 15'o00400; dma_wdata = 12'o5555;
        sb.push_back('{1'b1, 15'o00400, 12'o5555});
        tick;
        check("clr_we", {31'd0, mem_we}, 1);
        clear = 1; data_break = 0;
        tick;
        clear = 0;
        check("clr_bip", {31'd0, break_in_prog}, 0);
        check("clr_ack", {31'd0, db_ack}, 0);
        check("clr_we_off", {31'd0, mem_we}, 0);
        tick;
        check("clr_no_ack", ack_cnt, n0);
        check("clr_mem", {20'd0, mem[15'o00400]}, {20'd0, 12'o5555});

        // withdrawn request
        n0 = strobe_cyc.size();
        data_break = 1; cpu_idle = 0;
        tick; tick; tick;
        data_break = 0;
        tick;
        cpu_idle = 1;
        tick; tick;
        check("withdraw_bip", {31'd0, break_in_prog}, 0);
        check("withdraw_no_strobe", strobe_cyc.size(), n0);

        // asynchronous reset mid-WAIT
        data_break = 1; cpu_idle = 0;
        tick; tick;
        #2;
        reset = 0;
        #1;
        all_zero("async_rst");
        data_break = 0;
        tick;
        reset = 1;
        tick; tick;
        check("post_rst_bip", {31'd0, break_in_prog}, 0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_break_ctrl.md
DATA_BREAK_CTRL -- requirements
Module: data_break_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 64: cycles a pending break may wait for a CPU break slot before late_err sets.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 clear  input  1  IOCLR; synchronous, active-high.
REQ-005 data_break  input  1  level break request from the disk controller.
REQ-006 to_disk  input  1  1 = memory read (data to disk); 0 = memory write (data from disk).
REQ-007 dma_addr  input  15  extended memory address of the transfer (field in bits 0:2).
REQ-008 dma_wdata  input  12  word from the disk controller to be written to memory.
REQ-009 cpu_idle  input  1  CPU is at a break-eligible boundary this cycle.
REQ-010 break_in_prog  output  1  break owns memory; CPU holds off.
REQ-011 db_ack  output  1  one-cycle pulse in DB1; the disk controller drops data_break on it.
REQ-012 dma_rdata  output  12  word read from memory for the disk controller.
REQ-013 mem_addr  output  15  memory address.
REQ-014 mem_wdata  output  12  memory write data.
REQ-015 mem_re / mem_we  output  1 each  one-cycle memory strobes.
REQ-016 mem_rdata  input  12  memory read data, valid the cycle after mem_re.
REQ-017 late_err  output  1  sticky: a request waited MAX_WAIT cycles.

Function
REQ-018 FSM states: IDLE, WAIT, DB0, DB1, GUARD.
REQ-019 IDLE: data_break=1 and cpu_idle=1 -> DB0 next edge; data_break=1 and cpu_idle=0 -> WAIT.
REQ-020 WAIT: cpu_idle=1 -> DB0; data_break=0 (withdrawn) -> IDLE, no memory cycle.
REQ-021 On entry to DB0: latch dma_addr, dma_wdata and to_disk; later input changes do not affect the transfer.
REQ-022 DB0: mem_addr = latched address; mem_re=1 if to_disk=1, else mem_we=1 with mem_wdata = latched data; exactly one strobe, one cycle.
REQ-023 DB1: on a read, register mem_rdata into dma_rdata; db_ack=1 for exactly one cycle; next state GUARD.
REQ-024 GUARD: one cycle; data_break ignored; next state IDLE. This prevents retrigger while the request falls.
REQ-025 break_in_prog=1 in DB0, DB1 and GUARD; 0 in IDLE and WAIT.
REQ-026 Latency: request with cpu_idle high -> mem strobe 1 cycle later -> db_ack 2 cycles later -> IDLE 4 cycles later.
REQ-027 dma_rdata holds its value until the next read completes; writes do not alter it.
REQ-028 Wait counter: clears on entry to WAIT; increments each WAIT cycle; saturates at MAX_WAIT; width $clog2(MAX_WAIT)+1.
REQ-029 When the wait counter reaches MAX_WAIT, late_err sets and stays set. The request is still serviced.
REQ-030 late_err clears only on reset or clear.
REQ-031 clear=1: next edge -> IDLE, counter=0, late_err=0, strobes=0, db_ack=0. Any strobe already driven this cycle is not suppressed. clear has priority over all transitions.
REQ-032 clear=1 in DB0: the strobe of that cycle completes; DB1 is skipped, so no db_ack is issued.
REQ-033 A new request is accepted no earlier than the cycle after GUARD. Back-to-back breaks cost at least 4 cycles each.

Reset
REQ-034 Asynchronous reset=0 forces: state IDLE, break_in_prog=0, db_ack=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, dma_rdata=0, late_err=0, counter=0.
REQ-035 Reset deassertion takes effect at the first rising clk edge after reset goes high. Reset mid-transfer abandons the transfer without acknowledgement.

Structure
REQ-036 The state enum type dbSTATE_t (IDLE, WAIT, DB0, DB1, GUARD) belongs in the shared package alongside the SD types, so CPU and disk logic decode DB1 identically.
REQ-037 The MAX_WAIT default constant belongs in the shared parameters include.
REQ-038 Single module with no sub-modules. The wait counter is inline.

Verification
REQ-039 Read, cpu_idle=1: to_disk=1, dma_addr=15'o12345, memory[12345]=12'o7070 -> mem_re at +1; db_ack at +2; dma_rdata=7070 at +3.
REQ-040 Write, CPU busy 5 cycles: to_disk=0, dma_addr=15'o00200, dma_wdata=12'o1234 -> WAIT 5 cycles; mem_we with 1234 @ 00200 one cycle after cpu_idle rises; late_err=0.
REQ-041 Starvation: MAX_WAIT=8, cpu_idle=0 for 20 cycles -> late_err=1 at the 8th WAIT cycle; transfer completes when cpu_idle rises; late_err stays 1 until clear.
REQ-042 Held request: data_break held high through GUARD -> exactly one memory cycle, then a second break starting no earlier than 4 cycles after the first strobe.
REQ-043 Clear in DB0 (write): mem_we seen once, no db_ack, state IDLE next cycle; a reset pulse mid-WAIT -> all outputs 0 immediately, without waiting for a clock edge.
